// File: rtl/vga_fill_pkg.sv
// Shared definitions for the rectangle-fill sequencer: CSR map, CTRL/STATUS
// bit positions, sequencer states and the plot-slave word format.
package vga_fill_pkg;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_ORIGIN = 2'd1;
  localparam logic [1:0] CSR_SIZE   = 2'd2;
  localparam logic [1:0] CSR_COLOUR = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_IRQ_EN = 1;
  localparam int STAT_DONE   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  function automatic logic [31:0] plot_word(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic [7:0] colour);
    return {y, x, 8'h00, colour};
  endfunction

endpackage

// File: rtl/vga_fill_scan.sv
// Raster counter for one fill job: walks (cx, cy) row-major over the
// rectangle, with 9-bit end values so origins near 255 never wrap.
module vga_fill_scan #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       advance_i,
  input  logic [7:0] x0_i,
  input  logic [7:0] y0_i,
  input  logic [7:0] w_i,
  input  logic [7:0] h_i,
  output logic [8:0] cx_o,
  output logic [8:0] cy_o,
  output logic       in_bounds_o,
  output logic       last_o
);

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  logic [8:0] cx_q, cx_d, cy_q, cy_d;
  logic [8:0] x_end, y_end, cx_inc, cy_inc;

  assign x_end  = {1'b0, x0_i} + {1'b0, w_i};
  assign y_end  = {1'b0, y0_i} + {1'b0, h_i};
  assign cx_inc = cx_q + 9'd1;
  assign cy_inc = cy_q + 9'd1;

  assign in_bounds_o = (cx_q < W_LIM) && (cy_q < H_LIM);
  assign last_o      = (cx_inc == x_end) && (cy_inc == y_end);
  assign cx_o        = cx_q;
  assign cy_o        = cy_q;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      cx_d = {1'b0, x0_i};
      cy_d = {1'b0, y0_i};
    end else if (advance_i) begin
      if (cx_inc == x_end) begin
        cx_d = {1'b0, x0_i};
        cy_d = cy_inc;
      end else begin
        cx_d = cx_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/vga_fill_ctrl.sv
// Avalon-MM rectangle-fill sequencer: CSR slave, job FSM and plot-write
// master. Valid/ready: plot_write is the valid, !plot_waitrequest the ready.
module vga_fill_ctrl
  import vga_fill_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        plot_write,
  output logic [31:0] plot_writedata,
  input  logic        plot_waitrequest,
  output logic        irq
);

  fill_state_e state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d, colour_q, colour_d;
  logic        irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d;
  logic        ctrl_wr, start_acc, zero_size, load, advance;
  logic [8:0]  cx, cy;
  logic        in_bounds, last;
  logic        unused_ok;

  assign unused_ok = &{1'b0, read, writedata[31:16], cx[8], cy[8]};

  assign ctrl_wr   = write && (address == CSR_CTRL);
  assign zero_size = (w_q == 8'd0) || (h_q == 8'd0);
  assign start_acc = ctrl_wr && writedata[CTRL_START] && (state_q == ST_IDLE);

  vga_fill_scan #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load),
    .advance_i   (advance),
    .x0_i        (x0_q),
    .y0_i        (y0_q),
    .w_i         (w_q),
    .h_i         (h_q),
    .cx_o        (cx),
    .cy_o        (cy),
    .in_bounds_o (in_bounds),
    .last_o      (last)
  );

  // Clipped pixels advance without a bus cycle; in-screen ones wait for acceptance.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    advance    = 1'b0;
    plot_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          load    = 1'b1;
          state_d = zero_size ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        plot_write = in_bounds;
        advance    = in_bounds ? !plot_waitrequest : 1'b1;
        if (advance && last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign plot_writedata = plot_write ? plot_word(cx[7:0], cy[7:0], colour_q) : 32'h0;
  assign irq            = done_q && irq_en_q;

  // Job geometry and colour are frozen while busy so the running job is stable.
  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    colour_d = colour_q;
    irq_en_d = irq_en_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (write && !busy_q) begin
      case (address)
        CSR_ORIGIN: {y0_d, x0_d} = writedata[15:0];
        CSR_SIZE:   {h_d, w_d}   = writedata[15:0];
        CSR_COLOUR: colour_d     = writedata[7:0];
        default: ;
      endcase
    end
    if (ctrl_wr) begin
      irq_en_d = writedata[CTRL_IRQ_EN];
      if (writedata[CTRL_CLR_DONE]) done_d = 1'b0;
    end
    if (start_acc) begin
      done_d = 1'b0;
      busy_d = !zero_size;
    end
    if (state_q == ST_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      CSR_CTRL: begin
        readdata[STAT_BUSY]   = busy_q;
        readdata[STAT_IRQ_EN] = irq_en_q;
        readdata[STAT_DONE]   = done_q;
      end
      CSR_ORIGIN: readdata[15:0] = {y0_q, x0_q};
      CSR_SIZE:   readdata[15:0] = {h_q, w_q};
      CSR_COLOUR: readdata[7:0]  = colour_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      colour_q <= colour_d;
      irq_en_q <= irq_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Bench for vga_fill_ctrl: directed and randomized fill jobs checked against
// a nested-loop model of the clipped rectangle.
module tb_vga_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        plot_write;
  logic [31:0] plot_writedata;
  logic        plot_waitrequest = 1'b0;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] trace_q[$];
  int oob_cnt = 0;
  int hold_err = 0;
  logic prev_stalled = 1'b0;
  logic [31:0] prev_data = '0;

  vga_fill_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .address          (address),
    .read             (read),
    .readdata         (readdata),
    .write            (write),
    .writedata        (writedata),
    .plot_write       (plot_write),
    .plot_writedata   (plot_writedata),
    .plot_waitrequest (plot_waitrequest),
    .irq              (irq)
  );

  // clock
  always #5 clk = ~clk;

  // plot-bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (plot_write && !plot_waitrequest) got_q.push_back(plot_writedata);
      if (plot_write && (plot_writedata[23:16] >= 8'd160 || plot_writedata[31:24] >= 8'd120))
        oob_cnt++;
      if (prev_stalled && (!plot_write || plot_writedata !== prev_data)) hold_err++;
      prev_stalled = plot_write && plot_waitrequest;
      prev_data    = plot_writedata;
    end else begin
      prev_stalled = 1'b0;
    end
  end

  // reference model: every in-screen pixel of the rectangle, row-major
  function automatic void build_exp(input int x0, input int y0, input int w, input int h,
                                    input logic [7:0] col);
    exp_q.delete();
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        if (xx < 160 && yy < 120) exp_q.push_back({8'(yy), 8'(xx), 8'h00, col});
  endfunction

  // driver tasks
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; read = 1'b1;
    #1 d = readdata;
    read = 1'b0;
  endtask

  // mode 0: random stall at stall_pct; 1: first pixel stalled 3 cycles;
  // 2: random stall plus COLOUR write and second start while busy
  task automatic run_job(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                         input logic [7:0] h, input logic [7:0] col, input logic irq_en,
                         input int stall_pct, input int mode, output int lat, output int ilat);
    int k;
    bit done_seen;
    got_q.delete();
    trace_q.delete();
    csr_write(2'd1, {16'h0, y0, x0});
    csr_write(2'd2, {16'h0, h, w});
    csr_write(2'd3, {24'h0, col});
    @(posedge clk); #1;
    plot_waitrequest = (mode == 1);
    address = 2'd0; writedata = {29'h0, 1'b0, irq_en, 1'b1}; write = 1'b1; read = 1'b1;
    k = 0; lat = -1; ilat = -1; done_seen = 0;
    while (!done_seen && k < 30000) begin
      @(negedge clk);
      if (lat < 0 && plot_write) lat = k;
      if (ilat < 0 && irq) ilat = k;
      if (k < 8) trace_q.push_back(plot_writedata);
      if (!write && address == 2'd0 && readdata[2]) done_seen = 1;
      @(posedge clk); #1;
      write = 1'b0; address = 2'd0; read = 1'b1;
      if (mode == 1) plot_waitrequest = (k + 1 <= 3);
      else plot_waitrequest = ($urandom_range(0, 99) < stall_pct);
      if (mode == 2 && k == 50) begin address = 2'd3; writedata = 32'h0; write = 1'b1; end
      if (mode == 2 && k == 100) begin address = 2'd0; writedata = 32'h1; write = 1'b1; end
      k++;
    end
    plot_waitrequest = 1'b0; write = 1'b0; read = 1'b0;
    n_cmp++;
    if (!done_seen) begin
      n_bad++;
      $display("FAIL job_timeout: no done after %0d cycles, expected done", k);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_bad++; $display("FAIL reset_csr%0d: got %h expected 00000000", a, d);
      end
    end
    n_cmp++;
    if ({plot_write, irq, plot_writedata} !== 34'h0) begin
      n_bad++; $display("FAIL reset_outputs: pw=%b irq=%b data=%h expected all 0",
                        plot_write, irq, plot_writedata);
    end
  endtask

  task automatic test_basic();
    int lat, ilat, errs;
    logic [31:0] d;
    run_job(8'd10, 8'd20, 8'd3, 8'd2, 8'hFF, 1'b0, 0, 0, lat, ilat);
    build_exp(10, 20, 3, 2, 8'hFF);
    n_cmp++;
    if (got_q.size() != 6) begin
      n_bad++; $display("FAIL basic_count: got %0d writes expected 6", got_q.size());
    end
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) errs++;
    n_cmp++;
    if (errs != 0 || got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL basic_order: %0d words differ, got[0] %h expected %h", errs,
                        got_q[0], exp_q[0]);
    end
    n_cmp++;
    if (got_q[0] !== 32'h140A00FF) begin
      n_bad++; $display("FAIL basic_first_word: got %h expected 140a00ff", got_q[0]);
    end
    n_cmp++;
    if (lat != 1) begin
      n_bad++; $display("FAIL basic_latency: got %0d expected 1", lat);
    end
    csr_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h4) begin
      n_bad++; $display("FAIL basic_status: got %h expected 00000004", d);
    end
  endtask

  task automatic test_clip();
    int lat, ilat, errs;
    run_job(8'd158, 8'd118, 8'd4, 8'd4, 8'h5A, 1'b0, 30, 0, lat, ilat);
    build_exp(158, 118, 4, 4, 8'h5A);
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) errs++;
    n_cmp++;
    if (got_q.size() != 4 || errs != 0) begin
      n_bad++; $display("FAIL clip_writes: got %0d writes (%0d differ) expected 4", got_q.size(), errs);
    end
    n_cmp++;
    if (oob_cnt != 0 || hold_err != 0) begin
      n_bad++; $display("FAIL clip_bounds: oob=%0d hold_err=%0d expected 0/0", oob_cnt, hold_err);
    end
  endtask

  task automatic test_backpressure();
    int lat, ilat, errs;
    logic [31:0] want;
    want = {8'd7, 8'd5, 8'h00, 8'h3C};
    run_job(8'd5, 8'd7, 8'd2, 8'd1, 8'h3C, 1'b0, 0, 1, lat, ilat);
    errs = 0;
    for (int i = 1; i <= 4; i++) if (trace_q[i] !== want) errs++;
    n_cmp++;
    if (errs != 0) begin
      n_bad++; $display("FAIL bp_hold: %0d of 4 stalled cycles differ, got[1] %h expected %h",
                        errs, trace_q[1], want);
    end
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== want || hold_err != 0) begin
      n_bad++; $display("FAIL bp_accepts: got %0d writes first %h hold_err %0d expected 2 %h 0",
                        got_q.size(), got_q[0], hold_err, want);
    end
  endtask

  task automatic test_zero_irq();
    int lat, ilat;
    logic [31:0] d;
    run_job(8'd0, 8'd0, 8'd0, 8'd5, 8'h12, 1'b1, 0, 0, lat, ilat);
    n_cmp++;
    if (got_q.size() != 0 || lat != -1) begin
      n_bad++; $display("FAIL zero_no_write: got %0d writes expected 0", got_q.size());
    end
    n_cmp++;
    if (ilat < 1 || ilat > 2) begin
      n_bad++; $display("FAIL zero_irq_latency: got %0d expected 1..2", ilat);
    end
    csr_write(2'd0, 32'h6);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL zero_irq_clear: got %b expected 0", irq);
    end
    csr_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_bad++; $display("FAIL zero_status: got %h expected 00000002", d);
    end
  endtask

  task automatic test_busy_protect();
    int lat, ilat, errs;
    logic [31:0] d;
    csr_write(2'd0, 32'h4);
    run_job(8'd0, 8'd0, 8'd160, 8'd120, 8'h55, 1'b0, 10, 2, lat, ilat);
    repeat (30) @(posedge clk);
    build_exp(0, 0, 160, 120, 8'h55);
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) errs++;
    n_cmp++;
    if (got_q.size() != 19200 || errs != 0) begin
      n_bad++; $display("FAIL busy_writes: got %0d writes (%0d differ) expected 19200", got_q.size(), errs);
    end
    csr_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h55) begin
      n_bad++; $display("FAIL busy_colour: got %h expected 00000055", d);
    end
    csr_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h4) begin
      n_bad++; $display("FAIL busy_status: got %h expected 00000004", d);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ilat, errs;
    int x0, y0, w, h;
    logic [7:0] col;
    for (int j = 0; j < 5; j++) begin
      x0 = (j == 4) ? $urandom_range(0, 255) : $urandom_range(150, 165);
      y0 = (j == 4) ? $urandom_range(0, 255) : $urandom_range(110, 125);
      w = $urandom_range(1, 12); h = $urandom_range(1, 12);
      col = 8'($urandom_range(0, 255));
      run_job(8'(x0), 8'(y0), 8'(w), 8'(h), col, 1'b0, 25, 0, lat, ilat);
      build_exp(x0, y0, w, h, col);
      errs = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) errs++;
      n_cmp++;
      if (got_q.size() != exp_q.size() || errs != 0) begin
        n_bad++; $display("FAIL rand_job%0d (%0d,%0d %0dx%0d): got %0d writes (%0d differ) expected %0d",
                          j, x0, y0, w, h, got_q.size(), errs, exp_q.size());
      end
    end
    n_cmp++;
    if (oob_cnt != 0 || hold_err != 0) begin
      n_bad++; $display("FAIL rand_bus: oob=%0d hold_err=%0d expected 0/0", oob_cnt, hold_err);
    end
  endtask

  task automatic test_reset_abort();
    logic pw_before;
    int n_before;
    logic [31:0] d;
    got_q.delete();
    csr_write(2'd1, {16'h0, 8'd30, 8'd30});
    csr_write(2'd2, {16'h0, 8'd20, 8'd20});
    csr_write(2'd3, 32'h77);
    csr_write(2'd0, 32'h3);
    repeat (15) @(negedge clk);
    pw_before = plot_write;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (pw_before !== 1'b1 || plot_write !== 1'b0 || plot_writedata !== 32'h0) begin
      n_bad++; $display("FAIL abort_async: pw before %b after %b data %h expected 1 0 0",
                        pw_before, plot_write, plot_writedata);
    end
    n_before = got_q.size();
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_bad++; $display("FAIL abort_csr%0d: got %h expected 00000000", a, d);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != n_before || irq !== 1'b0) begin
      n_bad++; $display("FAIL abort_quiet: %0d writes after reset, irq %b expected 0 0",
                        got_q.size() - n_before, irq);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_basic();
    test_clip();
    test_backpressure();
    test_zero_irq();
    test_busy_protect();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fill_ctrl.md
Name: vga_fill_ctrl

Overview:
- Avalon-MM rectangle-fill sequencer that sits between the CPU and the 160x120 monochrome VGA plot slave.
- The CPU programs an origin, a size and a colour, then writes start. The block then emits one plot write per in-screen pixel, using the plot slave's word format (y[31:24], x[23:16], colour[7:0]).
- The block clips to the screen, tracks busy/done status, and can raise an interrupt on completion.
- Purpose: offloads screen clears and box draws from the Nios software loop.

Parameters:
- SCREEN_W, 160, horizontal pixel count; x values >= SCREEN_W are clipped.
- SCREEN_H, 120, vertical pixel count; y values >= SCREEN_H are clipped.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  CSR word address.
- read  in  1  CSR read strobe.
- readdata  out  32  CSR read data, zero wait, zero latency.
- write  in  1  CSR write strobe.
- writedata  in  32  CSR write data.
- plot_write  out  1  plot master write strobe.
- plot_writedata  out  32  {y[7:0], x[7:0], 8'h00, colour[7:0]}.
- plot_waitrequest  in  1  plot slave stall.
- irq  out  1  level interrupt, equal to done & irq_en.

Behaviour:
- One clock. Reset is asynchronous and active-low (reset_n); ports are clk and reset_n.
- CSR map (readdata is combinational from address; unused bits read 0):
  - 0 CTRL/STATUS.
    - Write: bit0 start, bit1 irq_en (stored), bit2 clear_done.
    - Read: bit0 busy, bit1 irq_en, bit2 done.
  - 1 ORIGIN: x0[7:0], y0[15:8].
  - 2 SIZE: w[7:0], h[15:8].
  - 3 COLOUR: colour[7:0].
- Reset values: all CSRs 0, state IDLE, busy 0, done 0, plot_write 0, plot_writedata 0, irq 0.
- FSM states:
  - IDLE:
    - A CTRL write with bit0=1 loads cx=x0, cy=y0 and clears done.
    - If w==0 or h==0, go straight to DONE.
    - Otherwise go to RUN and set busy.
  - RUN, per cycle:
    - Compute cx, cy, x_end=x0+w and y_end=y0+h at 9 bits; there is no 8-bit wrap.
    - If cx<SCREEN_W and cy<SCREEN_H, assert plot_write with plot_writedata for (cx, cy). Hold both stable while plot_waitrequest=1. On the first cycle with plot_waitrequest=0, the pixel is accepted; advance.
    - If the pixel is out of bounds, do not write; advance in that same cycle, one cycle per clipped pixel.
    - Advance rule: cx+1; when cx+1==x_end, set cx=x0 and cy+1; when cy+1 also equals y_end, go to DONE.
  - DONE: for one cycle, set done=1, clear busy, return to IDLE.
- Scan order is row-major, top-left first. The total accepted writes equal the in-screen area of the rectangle.
- CSR writes to ORIGIN, SIZE and COLOUR while busy are ignored; the running job uses its latched values.
- A start while busy is ignored. irq_en and clear_done remain writable while busy.
- done is sticky until clear_done or the next start. If clear_done and start arrive in the same write, start wins and done ends at 0.
- plot_write is never asserted outside RUN. A pending write is never dropped or altered mid-waitrequest.
- Reset mid-job aborts immediately and restores all reset values. No write is completed after reset_n falls.
- Throughput with no stall: one pixel per clock. Latency from start write to the first plot_write is 1 cycle.

Decomposition:
- Package vga_fill_pkg holds:
  - The CSR address localparams (CSR_CTRL=0, CSR_ORIGIN=1, CSR_SIZE=2, CSR_COLOUR=3).
  - The CTRL bit indices.
  - The state enum typedef (IDLE, RUN, DONE).
  - A function that packs (x, y, colour) into the plot word.
- One sub-module, vga_fill_scan: the cx/cy raster counter with load, advance, in_bounds and last outputs. The top level keeps the CSRs, the FSM and the Avalon master handshake.

Test Plan:
- Basic fill: ORIGIN x=10 y=20, SIZE w=3 h=2, COLOUR 8'hFF, start.
  - Expect exactly 6 writes, in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21).
  - First write data is 32'h140A00FF. Then done=1 and busy=0.
- Clipping: ORIGIN x=158 y=118, SIZE w=4 h=4.
  - Expect 4 writes only: (158,118), (159,118), (158,119), (159,119).
  - No write has x>=160 or y>=120. 9-bit end values mean no wrap to x=0.
- Backpressure: a 2x1 job with plot_waitrequest held high for 3 cycles on the first pixel.
  - plot_writedata stays constant for 4 cycles, and exactly 2 writes are accepted.
- Zero size and irq: SIZE w=0 h=5 with irq_en=1, start.
  - No plot_write occurs. done=1 and irq=1 within 2 cycles.
  - clear_done drops irq the next cycle.
- Busy protection: during a 160x120 clear, write COLOUR=8'h00 and issue a second start.
  - All 19200 writes carry the original colour, and only one done occurs.
- Reset abort: assert reset_n=0 mid-job.
  - plot_write drops asynchronously, all CSRs read 0, and no further writes occur after release.
